// File: rtl/fwd_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: operand select
// encodings and the default register address width.
package fwd_ctrl_pkg;

  localparam int unsigned REG_AW = 2;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_cmp.sv
// Pure operand-select comparator: picks the newest live producer of src,
// skipping a load in MEM because its data is not ready until WB.
module fwd_cmp
  import fwd_ctrl_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic [AW-1:0] src_i,
  input  logic          use_i,
  input  logic          mem_live_i,
  input  logic          mem_load_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          wb_live_i,
  input  logic [AW-1:0] wb_rd_i,
  output fwd_sel_e      sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (use_i) begin
      if (mem_live_i && !mem_load_i && (mem_rd_i == src_i)) begin
        sel_o = FWD_EXMEM;
      end else if (wb_live_i && (wb_rd_i == src_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding/hazard controller: shadow EX/MEM/WB destination tags, operand
// forwarding selects, one-cycle load-use stall and a saturating stall counter.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_load,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_load_q, ex_load_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic              ex_use_rs_q, ex_use_rs_d;
  logic              ex_use_rt_q, ex_use_rt_d;

  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_load_q, mem_load_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;

  // WB never consults its load bit, so only valid/we/rd are kept there.
  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  fwd_sel_e sel_a, sel_b;

  always_comb begin
    stall = id_valid && !flush && ex_valid_q && ex_we_q && ex_load_q &&
            ((id_use_rs && (id_rs == ex_rd_q)) ||
             (id_use_rt && (id_rt == ex_rd_q)));
  end

  always_comb begin
    ex_valid_d  = id_valid && !stall && !flush;
    ex_we_d     = id_we;
    ex_load_d   = id_load;
    ex_rd_d     = id_rd;
    ex_rs_d     = id_rs;
    ex_rt_d     = id_rt;
    ex_use_rs_d = id_use_rs;
    ex_use_rt_d = id_use_rt;

    mem_valid_d = ex_valid_q;
    mem_we_d    = ex_we_q;
    mem_load_d  = ex_load_q;
    mem_rd_d    = ex_rd_q;

    wb_valid_d  = mem_valid_q;
    wb_we_d     = mem_we_q;
    wb_rd_d     = mem_rd_q;

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Payload fields are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    ex_we_q     <= ex_we_d;
    ex_load_q   <= ex_load_d;
    ex_rd_q     <= ex_rd_d;
    ex_rs_q     <= ex_rs_d;
    ex_rt_q     <= ex_rt_d;
    ex_use_rs_q <= ex_use_rs_d;
    ex_use_rt_q <= ex_use_rt_d;
    mem_we_q    <= mem_we_d;
    mem_load_q  <= mem_load_d;
    mem_rd_q    <= mem_rd_d;
    wb_we_q     <= wb_we_d;
    wb_rd_q     <= wb_rd_d;
  end

  // Selects depend only on stage registers, so they hold for the whole EX cycle.
  fwd_cmp #(.AW(REG_AW)) u_cmp_a (
    .src_i      (ex_rs_q),
    .use_i      (ex_valid_q && ex_use_rs_q),
    .mem_live_i (mem_valid_q && mem_we_q),
    .mem_load_i (mem_load_q),
    .mem_rd_i   (mem_rd_q),
    .wb_live_i  (wb_valid_q && wb_we_q),
    .wb_rd_i    (wb_rd_q),
    .sel_o      (sel_a)
  );

  fwd_cmp #(.AW(REG_AW)) u_cmp_b (
    .src_i      (ex_rt_q),
    .use_i      (ex_valid_q && ex_use_rt_q),
    .mem_live_i (mem_valid_q && mem_we_q),
    .mem_load_i (mem_load_q),
    .mem_rd_i   (mem_rd_q),
    .wb_live_i  (wb_valid_q && wb_we_q),
    .wb_rd_i    (wb_rd_q),
    .sel_o      (sel_b)
  );

  assign fwd_a     = sel_a;
  assign fwd_b     = sel_b;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: an instruction-level pipeline model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [1:0] id_rs;
  logic [1:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_we;
  logic [1:0] id_rd;
  logic       id_load;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
  logic [7:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  fwd_ctrl #(.REG_AW(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_we     (id_we),
    .id_rd     (id_rd),
    .id_load   (id_load),
    .flush     (flush),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit we;
    bit ld;
    bit urs;
    bit urt;
    int rd;
    int rs;
    int rt;
  } ent_t;

  ent_t m_ex, m_mem, m_wb;
  int   m_cnt   = 0;
  bit   started = 0;

  function automatic int m_stall();
    if (!id_valid || flush || !m_ex.v || !m_ex.we || !m_ex.ld) return 0;
    if (id_use_rs && int'(id_rs) == m_ex.rd) return 1;
    if (id_use_rt && int'(id_rt) == m_ex.rd) return 1;
    return 0;
  endfunction

  function automatic int m_sel(int src, bit use_it);
    if (!m_ex.v || !use_it) return 0;
    if (m_mem.v && m_mem.we && !m_mem.ld && m_mem.rd == src) return 1;
    if (m_wb.v && m_wb.we && m_wb.rd == src) return 2;
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances one instruction slot per clock.
  always @(posedge clk) begin
    int s;
    if (rst) begin
      m_ex.v  = 0;
      m_mem.v = 0;
      m_wb.v  = 0;
      m_cnt   = 0;
      started = 1;
    end else begin
      s = m_stall();
      if (s != 0 && m_cnt < 255) m_cnt++;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (id_valid && s == 0 && !flush) begin
        m_ex.v   = 1;
        m_ex.we  = id_we;
        m_ex.ld  = id_load;
        m_ex.urs = id_use_rs;
        m_ex.urt = id_use_rt;
        m_ex.rd  = int'(id_rd);
        m_ex.rs  = int'(id_rs);
        m_ex.rt  = int'(id_rt);
      end else begin
        m_ex.v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_fwd_a", 32'(fwd_a), 32'(m_sel(m_ex.rs, m_ex.urs)));
      chk("model_fwd_b", 32'(fwd_b), 32'(m_sel(m_ex.rt, m_ex.urt)));
      chk("model_stall", 32'(stall), 32'(m_stall()));
      chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
  end

  task automatic drv(bit v, int rs, int rt, bit urs, bit urt, bit we, int rd, bit ld);
    id_valid  = v;
    id_rs     = rs[1:0];
    id_rt     = rt[1:0];
    id_use_rs = urs;
    id_use_rt = urt;
    id_we     = we;
    id_rd     = rd[1:0];
    id_load   = ld;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    nop();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset_fwd_a", 32'(fwd_a), 32'd0);
    chk("reset_fwd_b", 32'(fwd_b), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_cnt", 32'(stall_cnt), 32'd0);

    // ALU back-to-back
    drain();
    drv(1, 0, 0, 0, 0, 1, 1, 0); tick();
    drv(1, 1, 2, 1, 1, 1, 3, 0); tick();
    nop(); #1;
    chk("b2b_fwd_a", 32'(fwd_a), 32'd1);
    chk("b2b_fwd_b", 32'(fwd_b), 32'd0);
    chk("b2b_stall", 32'(stall), 32'd0);

    // Distance two
    drain();
    drv(1, 0, 0, 0, 0, 1, 2, 0); tick();
    nop(); tick();
    drv(1, 2, 2, 1, 1, 1, 0, 0); tick();
    nop(); #1;
    chk("dist2_fwd_a", 32'(fwd_a), 32'd2);
    chk("dist2_fwd_b", 32'(fwd_b), 32'd2);

    // Double producer; rt matches but is not read
    drain();
    drv(1, 0, 0, 0, 0, 1, 3, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 3, 0); tick();
    drv(1, 3, 3, 1, 0, 1, 0, 0); tick();
    nop(); #1;
    chk("double_fwd_a", 32'(fwd_a), 32'd1);
    chk("double_fwd_b", 32'(fwd_b), 32'd0);

    // Load-use
    drain();
    drv(1, 0, 0, 0, 0, 1, 1, 1); tick();
    drv(1, 1, 0, 1, 0, 1, 2, 0); #1;
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_cnt_before", 32'(stall_cnt), 32'd0);
    tick();
    chk("lu_stall_released", 32'(stall), 32'd0);
    chk("lu_bubble_fwd_a", 32'(fwd_a), 32'd0);
    chk("lu_cnt_after", 32'(stall_cnt), 32'd1);
    tick();
    nop(); #1;
    chk("lu_fwd_a", 32'(fwd_a), 32'd2);

    // Flush during load-use
    drain();
    drv(1, 0, 0, 0, 0, 1, 1, 1); tick();
    drv(1, 1, 0, 1, 0, 1, 2, 0);
    flush = 1'b1; #1;
    chk("flush_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    nop(); #1;
    chk("flush_bubble_fwd_a", 32'(fwd_a), 32'd0);
    chk("flush_cnt", 32'(stall_cnt), 32'd1);

    // Non-reads: address matches but operand not used
    drain();
    drv(1, 0, 0, 0, 0, 1, 1, 0); tick();
    drv(1, 1, 1, 0, 0, 1, 2, 0); tick();
    nop(); #1;
    chk("noread_fwd_a", 32'(fwd_a), 32'd0);
    chk("noread_fwd_b", 32'(fwd_b), 32'd0);
    drain();
    drv(1, 0, 0, 0, 0, 1, 1, 1); tick();
    drv(1, 1, 1, 0, 0, 1, 2, 0); #1;
    chk("noread_stall", 32'(stall), 32'd0);
    tick();

    // Mid-stream reset
    drv(1, 0, 0, 0, 0, 1, 1, 0); tick();
    drv(1, 0, 0, 0, 0, 1, 1, 1); tick();
    drv(1, 1, 1, 1, 1, 1, 2, 0);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("rst_mid_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_mid_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    tick();
    nop(); #1;
    chk("first_after_rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("first_after_rst_fwd_b", 32'(fwd_b), 32'd0);

    // Saturation: back-to-back dependent loads stall every other cycle
    drain();
    drv(1, 2, 0, 1, 0, 1, 2, 1);
    repeat (620) tick();
    chk("sat_cnt", 32'(stall_cnt), 32'd255);
    chk("sat_model_cnt", 32'(m_cnt), 32'd255);
    drain();
    chk("sat_cnt_hold", 32'(stall_cnt), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding/hazard controller for the 8-bit pipeline; sits directly upstream of the forwarding operand muxes.
- Keeps a shadow pipeline of destination-register tags for the EX, MEM and WB stages.
- Generates the 2-bit select per ALU operand that the muxes consume: 00 = register-file value, 01 = EX/MEM ALU result (acout), 10 = MEM/WB data (mem).
- Detects load-use hazards, requests a one-cycle stall and counts stalls.

Parameters:
REG_AW, 2, register address width (4 architectural registers)
CNT_W, 8, width of the saturating stall counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_AW  source register A of the ID instruction
id_rt  input  REG_AW  source register B of the ID instruction
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
id_we  input  1  ID instruction writes a register
id_rd  input  REG_AW  destination register of the ID instruction
id_load  input  1  ID instruction is a memory load
flush  input  1  taken branch/jump: discard the ID instruction
fwd_a  output  2  select for operand A of the instruction now in EX
fwd_b  output  2  select for operand B of the instruction now in EX
stall  output  1  hold PC and IF/ID this cycle (combinational)
stall_cnt  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- One clock, synchronous active-high reset; no other clock or reset.
- Reset clears all stage valid bits and sets fwd_a = fwd_b = 2'b00, stall_cnt = 0. stall reads 0 while the EX slot is invalid.
- Shadow stages EX, MEM and WB each hold {valid, we, rd, load}. EX also holds rs, rt, use_rs, use_rt.
- Every edge:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields when id_valid & !stall & !flush; otherwise EX <= bubble (valid = 0).
- Effective write ("live"): a stage counts as writing only when valid & we.
- Operand A select, computed from the stage contents loaded on the same edge, so fwd_a is registered and stable for the whole EX cycle:
  - 01 if the incoming MEM entry is live and its rd == EX rs;
  - else 10 if the incoming WB entry is live and its rd == EX rs;
  - else 00.
- If EX.use_rs = 0 or EX.valid = 0, fwd_a = 00.
- Operand B is identical, using rt / use_rt / fwd_b.
- Newest producer wins: when both MEM and WB match, select 01.
- A load in MEM never yields 01. If the MEM entry has load = 1, that match is ignored and lower priority applies; the load-use stall guarantees this case reaches EX only as a bubble.
- stall = id_valid & !flush & EX live & EX.load & ((id_use_rs & id_rs == EX.rd) | (id_use_rt & id_rt == EX.rd)).
- Stall lasts exactly one cycle. Next cycle the load is in MEM, the consumer enters EX and gets 10 one cycle later, when the load sits in WB.
- flush has priority over stall: stall = 0 and a bubble enters EX.
- stall_cnt increments on every edge where stall = 1 and holds at all-ones (255).
- Reset mid-stream discards all in-flight tags. The first instruction after reset always sees 00/00.
- Non-reads: use_rs/use_rt = 0 never forwards and never stalls, even when register addresses match.

Decomposition:
- Shared package: the select encodings FWD_REG = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10, plus REG_AW.
- One natural sub-module, fwd_cmp: a pure comparator taking {src, use, MEM tag, WB tag} and returning the 2-bit select. Instantiate it twice, for A and B.
- Stage registers, stall logic and counter live in fwd_ctrl.

Test Plan:
- ALU back-to-back: ADD r1 (we, rd=1), then SUB reading rs=1 -> in the consumer's EX cycle fwd_a = 01, fwd_b = 00, stall = 0.
- Distance two: ADD r2, NOP, then AND rs=2, rt=2 -> fwd_a = fwd_b = 10.
- Double producer: ADD r3, ADD r3, then OR rs=3 -> fwd_a = 01 (newest wins).
- Load-use: LD r1, then ADD rs=1 -> stall = 1 for exactly one cycle with a bubble in EX; next EX cycle fwd_a = 10; stall_cnt goes 0 -> 1.
- Flush during a load-use: same sequence with flush = 1 in the stall cycle -> stall = 0, bubble inserted, stall_cnt unchanged.
- Reset and saturation:
  - rst asserted mid-stream -> fwd 00/00 and stall_cnt = 0 the next cycle.
  - 300 forced load-use stalls -> stall_cnt stops at 255.
